joypad_port: RTL and testbench
==============================

Name: joypad_port

Overview:
- CPU-bus responder for controller port 1 at $4016. It is the device end of the CPU core's memory-mapped read/write interface.
- Polls a physical NES controller through the latch/pulse/data serial protocol and keeps an 8-bit button image.
- Serves that image to CPU reads with NES strobe/shift semantics.
- Sits beside cpu_memory on the CPU bus; r_data is muxed by the memory decoder when r_hit is high.

Parameters:
- LATCH_TICKS, 12, clock_en ticks pad_latch is held high.
- PULSE_TICKS, 6, clock_en ticks for each half of a pad_pulse period.
- POLL_TICKS, 29780, clock_en ticks from the end of one poll to the start of the next.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clock_en  in  1  CPU cycle enable; all state advances only when high
- addr  in  16  CPU bus address
- mem_r_en  in  1  1 = read cycle, 0 = write cycle (qualified by clock_en)
- w_data  in  8  CPU write data
- r_data  out  8  registered read data
- r_hit  out  1  r_data is valid for a $4016 read issued the previous enabled cycle
- pad_latch  out  1  to controller latch pin
- pad_pulse  out  1  to controller clock pin
- pad_data  in  1  from controller, active-low button data
- buttons  out  8  committed image {Right,Left,Down,Up,Start,Select,B,A}, 1 = pressed

Behaviour:
- Interface: one clock (clock); synchronous active-high reset (reset). Every register updates on posedge clock only when clock_en = 1, except reset.
- Reset values:
  - r_data = 8'h00, r_hit = 0
  - pad_latch = 0, pad_pulse = 0, buttons = 8'h00
  - strobe = 0, shift_reg = 8'h00
  - poll FSM in IDLE with its timer = 0
  - Reset mid-poll aborts the poll; the partial sample is discarded.
- Bus write: clock_en && !mem_r_en && addr == 16'h4016 sets strobe <= w_data[0]. Other addresses are ignored.
- Shift register:
  - While strobe = 1, shift_reg reloads from buttons every enabled cycle.
  - A read returns buttons[0] (A) and does not shift.
  - The 1->0 edge leaves shift_reg frozen at the last reload.
- Bus read: clock_en && mem_r_en && addr == 16'h4016 has one-cycle latency.
  - Next cycle: r_hit = 1 and r_data = {7'b0100000, shift_reg[0]}. The 0x40 models open-bus.
  - When strobe = 0: shift_reg <= {1'b1, shift_reg[7:1]}, so reads 9+ return bit0 = 1.
  - r_hit is 0 on all other cycles; r_data holds its last value.
- Poll FSM, each state counting clock_en ticks:
  - IDLE: wait POLL_TICKS, then go to LATCH.
  - LATCH: pad_latch = 1 for LATCH_TICKS. Sample bit 0 = ~pad_data on the last tick, then go to PULSE_HI.
  - PULSE_HI: pad_pulse = 1 for PULSE_TICKS, then go to PULSE_LO.
  - PULSE_LO: pad_pulse = 0 for PULSE_TICKS. Sample the next bit = ~pad_data on the last tick.
    - If 8 bits have been sampled, go to COMMIT.
    - Otherwise go to PULSE_HI.
  - COMMIT: one tick; buttons <= sample; go to IDLE with the timer cleared.
- Bit order sampled: A, B, Select, Start, Up, Down, Left, Right into bits 0..7.
- Outputs: pad_latch and pad_pulse are registered and never high simultaneously.
- Commit during strobe = 1: the new buttons value is visible on the next reload. Commit during strobe = 0: the shift_reg in progress is unaffected.
- Read at the same enabled cycle as COMMIT: the read uses the pre-commit shift_reg.
- Counter widths: $clog2 of the largest parameter + 1. All parameters must be ≥ 1.

Optional Feature:
- JOYPAD_DEBOUNCE_EN defined:
  - COMMIT updates buttons only if the new sample equals the previous poll's sample. The first poll after reset never commits.
  - The previous-sample register is reset to 8'h00.
- Undefined: every COMMIT updates buttons unconditionally.

Test Plan:
- Parameters for the directed tests: LATCH_TICKS=2, PULSE_TICKS=1, POLL_TICKS=4, clock_en=1.
- Basic poll: pad drives pattern A and Start pressed (pad_data low on bits 0 and 3) -> after the first poll completes, buttons = 8'h09. pad_latch is high for exactly 2 cycles, followed by 7 pad_pulse high cycles.
- Strobe and read-out with buttons = 8'h09:
  - Write 8'h01 then 8'h00 to $4016, then perform 10 reads.
  - r_data sequence: 41, 40, 40, 41, 40, 40, 40, 40, 41, 41.
  - r_hit is high one cycle after each read.
- Strobe held high: write 8'h01, then 3 reads -> each returns 8'h41; shift_reg does not advance.
- Reset mid-poll: assert reset during PULSE_LO of bit 4 -> the next cycle shows pad_latch = 0, pad_pulse = 0, buttons = 00. A full poll restarts after POLL_TICKS.
- Non-decode: read/write $4017 and $0000 -> r_hit stays 0 and strobe is unchanged. clock_en = 0 for 5 cycles -> FSM counters and outputs are frozen.
- Debounce (JOYPAD_DEBOUNCE_EN): polls see 8'h01, then 8'h03, then 8'h03 -> buttons stays 00, stays 00, then becomes 03.

Source files
------------

// File: rtl/joypad_port.sv
// NES controller port at $4016: polls a serial pad and serves strobe/shift reads to the CPU bus.
// Optional JOYPAD_DEBOUNCE_EN: commit only when two consecutive polls agree.
module joypad_port #(
  parameter int unsigned LATCH_TICKS = 12,
  parameter int unsigned PULSE_TICKS = 6,
  parameter int unsigned POLL_TICKS  = 29780
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_en,
  input  logic [15:0] addr,
  input  logic        mem_r_en,
  input  logic [7:0]  w_data,
  output logic [7:0]  r_data,
  output logic        r_hit,
  output logic        pad_latch,
  output logic        pad_pulse,
  input  logic        pad_data,
  output logic [7:0]  buttons
);

  localparam int unsigned MAX_LP = (LATCH_TICKS > PULSE_TICKS) ? LATCH_TICKS : PULSE_TICKS;
  localparam int unsigned MAX_T  = (MAX_LP > POLL_TICKS) ? MAX_LP : POLL_TICKS;
  localparam int unsigned TW     = $clog2(MAX_T) + 1;

  localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_TICKS - 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_TICKS - 1);
  localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_PULSE_HI,
    S_PULSE_LO,
    S_COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sample_q, sample_d;
  logic [7:0]    buttons_q, buttons_d;
  logic          latch_q, latch_d;
  logic          pulse_q, pulse_d;
`ifdef JOYPAD_DEBOUNCE_EN
  logic [7:0]    prev_q, prev_d;
`endif

  logic          strobe_q, strobe_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    r_data_q, r_data_d;
  logic          r_hit_q, r_hit_d;
  logic          dec;
  logic          unused_wdata;

  assign dec          = (addr == 16'h4016);
  assign unused_wdata = ^w_data[7:1];

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_d     = bit_q;
    sample_d  = sample_q;
    buttons_d = buttons_q;
`ifdef JOYPAD_DEBOUNCE_EN
    prev_d    = prev_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (timer_q == POLL_LAST) begin
          state_d = S_LATCH;
          timer_d = '0;
        end
      end
      S_LATCH: begin
        if (timer_q == LATCH_LAST) begin
          state_d     = S_PULSE_HI;
          timer_d     = '0;
          sample_d[0] = ~pad_data;
          bit_d       = 3'd1;
        end
      end
      S_PULSE_HI: begin
        if (timer_q == PULSE_LAST) begin
          state_d = S_PULSE_LO;
          timer_d = '0;
        end
      end
      S_PULSE_LO: begin
        if (timer_q == PULSE_LAST) begin
          timer_d         = '0;
          sample_d[bit_q] = ~pad_data;
          if (bit_q == 3'd7) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_PULSE_HI;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        timer_d = '0;
`ifdef JOYPAD_DEBOUNCE_EN
        if (sample_q == prev_q) buttons_d = sample_q;
        prev_d = sample_q;
`else
        buttons_d = sample_q;
`endif
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
    // Pin drives follow the next state so they are registered alongside it.
    latch_d = (state_d == S_LATCH);
    pulse_d = (state_d == S_PULSE_HI);
  end

  always_comb begin
    strobe_d = strobe_q;
    shift_d  = shift_q;
    r_data_d = r_data_q;
    r_hit_d  = 1'b0;
    if (dec && !mem_r_en) strobe_d = w_data[0];
    if (dec && mem_r_en) begin
      r_hit_d  = 1'b1;
      r_data_d = {7'b0100000, shift_q[0]};
    end
    // Strobe reload uses the registered image, so a same-cycle commit shows up one reload later.
    if (strobe_q) begin
      shift_d = buttons_q;
    end else if (dec && mem_r_en) begin
      shift_d = {1'b1, shift_q[7:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      sample_q  <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
      prev_q    <= '0;
`endif
      strobe_q  <= 1'b0;
      shift_q   <= '0;
      r_data_q  <= '0;
      r_hit_q   <= 1'b0;
    end else if (clock_en) begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      sample_q  <= sample_d;
      buttons_q <= buttons_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
`ifdef JOYPAD_DEBOUNCE_EN
      prev_q    <= prev_d;
`endif
      strobe_q  <= strobe_d;
      shift_q   <= shift_d;
      r_data_q  <= r_data_d;
      r_hit_q   <= r_hit_d;
    end
  end

  assign r_data    = r_data_q;
  assign r_hit     = r_hit_q;
  assign pad_latch = latch_q;
  assign pad_pulse = pulse_q;
  assign buttons   = buttons_q;

endmodule

// File: tb/tb_joypad_port.sv
// Directed bench for joypad_port with a behavioural NES pad driven by the pad pins.
module tb_joypad_port;
  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        clock_en = 1'b1;
  logic [15:0] addr     = 16'h0000;
  logic        mem_r_en = 1'b1;
  logic [7:0]  w_data   = 8'h00;
  logic [7:0]  r_data;
  logic        r_hit;
  logic        pad_latch;
  logic        pad_pulse;
  logic        pad_data;
  logic [7:0]  buttons;

  logic [7:0]  pat = 8'h09;
  logic [3:0]  idx = 4'd0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

`ifdef JOYPAD_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  joypad_port #(
    .LATCH_TICKS(2),
    .PULSE_TICKS(1),
    .POLL_TICKS (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .clock_en (clock_en),
    .addr     (addr),
    .mem_r_en (mem_r_en),
    .w_data   (w_data),
    .r_data   (r_data),
    .r_hit    (r_hit),
    .pad_latch(pad_latch),
    .pad_pulse(pad_pulse),
    .pad_data (pad_data),
    .buttons  (buttons)
  );

  always #5 clock = ~clock;

  // Pad model: latch selects bit 0, each pulse rising edge advances one bit; active-low output.
  always @(posedge pad_latch or posedge pad_pulse) begin
    if (pad_latch) idx <= 4'd0;
    else           idx <= idx + 4'd1;
  end
  assign pad_data = (idx < 4'd8) ? ~pat[idx[2:0]] : 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr     = a;
    mem_r_en = 1'b0;
    w_data   = d;
    step(1);
    addr     = 16'h0000;
    mem_r_en = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] a, input logic exp_hit,
                          input logic [7:0] exp_data);
    addr     = a;
    mem_r_en = 1'b1;
    step(1);
    addr     = 16'h0000;
    check({tag, "_hit"}, {7'b0, r_hit}, {7'b0, exp_hit});
    if (exp_hit) check({tag, "_data"}, r_data, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] seq [10];
    int unsigned lat_cnt, pul_cnt, both_cnt;
    logic found;

    seq = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};

    // Reset state and basic poll
    pat = 8'h09;
    do_reset();
    check("rst_r_data", r_data, 8'h00);
    check("rst_r_hit", {7'b0, r_hit}, 8'h00);
    check("rst_latch", {7'b0, pad_latch}, 8'h00);
    check("rst_pulse", {7'b0, pad_pulse}, 8'h00);
    check("rst_buttons", buttons, 8'h00);
    lat_cnt = 0; pul_cnt = 0; both_cnt = 0;
    for (int k = 1; k <= 21; k++) begin
      step(1);
      if (pad_latch) lat_cnt++;
      if (pad_pulse) pul_cnt++;
      if (pad_latch && pad_pulse) both_cnt++;
      if (k == 4) check("latch_start", {7'b0, pad_latch}, 8'h01);
      if (k == 20) check("pre_commit", buttons, 8'h00);
    end
    check("poll1_buttons", buttons, DEB ? 8'h00 : 8'h09);
    check("latch_cycles", lat_cnt[7:0], 8'd2);
    check("pulse_cycles", pul_cnt[7:0], 8'd7);
    check("latch_pulse_overlap", both_cnt[7:0], 8'd0);
    step(21);
    check("poll2_buttons", buttons, 8'h09);

    // Strobe then ten reads
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) bus_read($sformatf("read%0d", i), 16'h4016, 1'b1, seq[i]);
    step(1);
    check("idle_hit", {7'b0, r_hit}, 8'h00);
    check("idle_hold", r_data, 8'h41);

    // Strobe held high: reads do not advance
    bus_write(16'h4016, 8'h01);
    for (int i = 0; i < 3; i++) bus_read($sformatf("strobe%0d", i), 16'h4016, 1'b1, 8'h41);
    bus_write(16'h4016, 8'h00);
    bus_read("after_strobe0", 16'h4016, 1'b1, 8'h41);
    bus_read("after_strobe1", 16'h4016, 1'b1, 8'h40);

    // Non-decoded addresses
    bus_write(16'h4017, 8'h01);
    bus_write(16'h0000, 8'h01);
    bus_read("nd4017", 16'h4017, 1'b0, 8'h00);
    bus_read("nd0000", 16'h0000, 1'b0, 8'h00);
    bus_read("nd_then0", 16'h4016, 1'b1, 8'h40);
    bus_read("nd_then1", 16'h4016, 1'b1, 8'h41);

    // Reset during PULSE_LO of bit 4
    check("pre_mid_buttons", buttons, 8'h09);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step(1);
      if (idx == 4'd4 && !pad_pulse && !pad_latch) found = 1'b1;
    end
    check("mid_poll_found", {7'b0, found}, 8'h01);
    pat = 8'h5A;
    do_reset();
    check("mid_rst_latch", {7'b0, pad_latch}, 8'h00);
    check("mid_rst_pulse", {7'b0, pad_pulse}, 8'h00);
    check("mid_rst_buttons", buttons, 8'h00);
    for (int k = 1; k <= 21; k++) begin
      step(1);
      if (k == 3) check("restart_idle", {7'b0, pad_latch}, 8'h00);
      if (k == 4) check("restart_latch", {7'b0, pad_latch}, 8'h01);
      if (k == 20) check("restart_pre", buttons, 8'h00);
    end
    check("restart_buttons", buttons, DEB ? 8'h00 : 8'h5A);

    // clock_en low freezes everything
    do_reset();
    step(4);
    check("freeze_entry", {7'b0, pad_latch}, 8'h01);
    clock_en = 1'b0;
    addr     = 16'h4016;
    mem_r_en = 1'b1;
    step(5);
    check("freeze_latch", {7'b0, pad_latch}, 8'h01);
    check("freeze_pulse", {7'b0, pad_pulse}, 8'h00);
    check("freeze_hit", {7'b0, r_hit}, 8'h00);
    clock_en = 1'b1;
    addr     = 16'h0000;
    step(1);
    check("thaw_latch", {7'b0, pad_latch}, 8'h01);
    step(1);
    check("thaw_latch_end", {7'b0, pad_latch}, 8'h00);
    check("thaw_pulse", {7'b0, pad_pulse}, 8'h01);
    step(15);
    check("thaw_buttons", buttons, DEB ? 8'h00 : 8'h5A);

    // Poll sequence 01, 03, 03
    pat = 8'h01;
    do_reset();
    step(21);
    check("seq_poll1", buttons, DEB ? 8'h00 : 8'h01);
    pat = 8'h03;
    step(21);
    check("seq_poll2", buttons, DEB ? 8'h00 : 8'h03);
    step(21);
    check("seq_poll3", buttons, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
